// File: rtl/eth_rx_pkg.sv
// Shared Ethernet types for the MAC front ends (eth_tx / eth_rx).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: e_ether_type, st_eth_packet (480 bits, first wire byte in [479:472]),
//           CRC-32 constants and the header+payload capture depth.
package Types;

    typedef enum logic [15:0] {
        ETH_TYPE_IPV4 = 16'h0800,
        ETH_TYPE_ARP  = 16'h0806
    } e_ether_type;

    // dst/src/type/first 46 payload bytes; dst is the first byte on the wire
    typedef struct packed {
        logic [47:0]  dst;
        logic [47:0]  src;
        logic [15:0]  ether_type;
        logic [367:0] payload;
    } st_eth_packet;

    localparam logic [31:0] CRC32_POLY_REFL       = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE         = 32'hDEBB20E3;
    localparam int          ETH_HDR_PAYLOAD_BYTES = 60;

endpackage

// File: rtl/eth_rx_if.sv
// RMII receive bundle between the PHY side and the eth_rx MAC front end.
// Latency: n/a (wiring only).
// Backpressure: none; RMII is a free-running stream, results are pulses.
//
// Signals: eth_rxd/eth_crsdv from the PHY, eth_packet/pkt_valid/pkt_error back.
// Modports: master = PHY / stimulus side, slave = eth_rx.
interface eth_rx_if;
    import Types::*;

    logic [1:0]   eth_rxd;
    logic         eth_crsdv;
    st_eth_packet eth_packet;
    logic         pkt_valid;
    logic         pkt_error;

    modport master (
        output eth_rxd, eth_crsdv,
        input  eth_packet, pkt_valid, pkt_error
    );

    modport slave (
        input  eth_rxd, eth_crsdv,
        output eth_packet, pkt_valid, pkt_error
    );

endinterface

// File: rtl/eth_rx_crc32_dibit.sv
// Reflected CRC-32 (poly EDB88320) advancing two bits per clock, LSB first.
// Latency: crc reflects a dibit one cycle after en; init has priority over en.
// Backpressure: none; en simply holds the register when low.
//
// Ports: eth_clk, rst_in (sync, active-high), init, en, d[1:0] -> crc[31:0].
// No final inversion is applied, so running over data+FCS leaves the residue.
module crc32_dibit
    import Types::*;
(
    input  logic        eth_clk,
    input  logic        rst_in,
    input  logic        init,
    input  logic        en,
    input  logic [1:0]  d,
    output logic [31:0] crc
);

    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    // d[0] is the earlier bit on the wire, so it is folded in first
    always_comb begin
        w_crc_next = r_crc;
        for (int i = 0; i < 2; i++) begin
            if (w_crc_next[0] ^ d[i]) begin
                w_crc_next = (w_crc_next >> 1) ^ CRC32_POLY_REFL;
            end else begin
                w_crc_next = w_crc_next >> 1;
            end
        end
    end

    always_ff @(posedge eth_clk) begin
        if (rst_in || init) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (en) begin
            r_crc <= w_crc_next;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/eth_rx.sv
// RMII receive front end: strips preamble/SFD, captures dst/src/type/46 payload bytes, checks length (+FCS).
// Latency: pkt_valid/pkt_error pulse one cycle after eth_crsdv is sampled low at frame end.
// Backpressure: none; eth_packet is held until the next good frame overwrites it.
//
// Ports: eth_clk, rst_in (sync, active-high), bus (eth_rx_if.slave: eth_rxd, eth_crsdv in;
//        eth_packet, pkt_valid, pkt_error out).
// Build option: define ETH_RX_FCS_CHECK_EN to instantiate crc32_dibit and reject FCS mismatches.
module eth_rx
    import Types::*;
#(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic    eth_clk,
    input  logic    rst_in,
    eth_rx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} e_rx_state;

    localparam logic [10:0] MIN_CNT      = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] MAX_CNT      = 11'(MAX_FRAME_BYTES);
    localparam logic [10:0] SHADOW_BYTES = 11'(ETH_HDR_PAYLOAD_BYTES);

    e_rx_state                           r_state;
    logic [1:0]                          r_dib_idx;
    logic [5:0]                          r_byte;      // three most recent dibits of the byte in flight
    logic [10:0]                         r_byte_cnt;
    logic [ETH_HDR_PAYLOAD_BYTES*8-1:0]  r_shadow;
    st_eth_packet                        r_packet;
    logic                                r_pkt_valid;
    logic                                r_pkt_error;

    logic [7:0] w_byte_next;
    logic [8:0] w_wr_lsb;
    logic       w_fcs_ok;
    logic       w_frame_good;

    // LSB-first dibits: the dibit arriving now is the top two bits of the byte
    assign w_byte_next = {bus.eth_rxd, r_byte};

    // byte n lands at [479-8n -: 8]; only evaluated while n < 60
    assign w_wr_lsb = 9'd472 - {r_byte_cnt[5:0], 3'b000};

`ifdef ETH_RX_FCS_CHECK_EN
    logic        w_crc_init;
    logic        w_crc_en;
    logic [31:0] w_crc;

    // restart on the SFD tail so the first dst dibit is the first one folded in
    assign w_crc_init = (r_state == PREAMBLE) && bus.eth_crsdv && (bus.eth_rxd == 2'b11);
    assign w_crc_en   = (r_state == DATA) && bus.eth_crsdv;

    crc32_dibit u_crc (
        .eth_clk (eth_clk),
        .rst_in  (rst_in),
        .init    (w_crc_init),
        .en      (w_crc_en),
        .d       (bus.eth_rxd),
        .crc     (w_crc)
    );

    assign w_fcs_ok = (w_crc == CRC32_RESIDUE);
`else
    assign w_fcs_ok = 1'b1;
`endif

    assign w_frame_good = (r_dib_idx == 2'd0) &&
                          (r_byte_cnt >= MIN_CNT) &&
                          (r_byte_cnt <= MAX_CNT) &&
                          w_fcs_ok;

    always_ff @(posedge eth_clk) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_dib_idx   <= 2'd0;
            r_byte      <= 6'd0;
            r_byte_cnt  <= 11'd0;
            r_shadow    <= '0;
            r_packet    <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_error <= 1'b0;
        end else begin
            r_pkt_valid <= 1'b0;
            r_pkt_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.eth_crsdv) begin
                        r_state <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (!bus.eth_crsdv) begin
                        r_state <= IDLE;
                    end else if (bus.eth_rxd == 2'b11) begin
                        r_state    <= DATA;
                        r_dib_idx  <= 2'd0;
                        r_byte_cnt <= 11'd0;
                    end else if (bus.eth_rxd == 2'b10) begin
                        r_state <= DROP;
                    end
                end
                DATA: begin
                    // carrier loss mid-byte also lands here and fails the alignment check
                    if (!bus.eth_crsdv) begin
                        r_state <= IDLE;
                        if (w_frame_good) begin
                            r_packet    <= r_shadow;
                            r_pkt_valid <= 1'b1;
                        end else begin
                            r_pkt_error <= 1'b1;
                        end
                    end else begin
                        r_byte    <= {bus.eth_rxd, r_byte[5:2]};
                        r_dib_idx <= r_dib_idx + 2'd1;
                        if (r_dib_idx == 2'd3) begin
                            if (r_byte_cnt < SHADOW_BYTES) begin
                                r_shadow[w_wr_lsb +: 8] <= w_byte_next;
                            end
                            // saturate so a very long frame can never wrap back into range
                            if (r_byte_cnt != 11'h7FF) begin
                                r_byte_cnt <= r_byte_cnt + 11'd1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (!bus.eth_crsdv) begin
                        r_state     <= IDLE;
                        r_pkt_error <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.eth_packet = r_packet;
    assign bus.pkt_valid  = r_pkt_valid;
    assign bus.pkt_error  = r_pkt_error;

endmodule
